// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbitration state and the
// request bundle used for the core, host and memory sides.
package dmem_arbiter_pkg;

    localparam int DMEM_AW = 9;
    localparam int DMEM_DW = 32;

    typedef enum logic {ARB_CORE, ARB_FORCE} dmem_arb_state_t;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
        logic [2:0]         func3;
    } dmem_req_t;

    // An idle request: no read, no write, all fields zero.
    function automatic dmem_req_t req_idle();
        return '0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, host and datamemory signals around the arbiter.
// slave = arbiter view, master = surrounding pipeline/host/memory view.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = DMEM_AW,
    parameter int DATA_W     = DMEM_DW
);
    // core MEM stage
    logic                  core_rd;
    logic                  core_wr;
    logic [DM_ADDRESS-1:0] core_addr;
    logic [DATA_W-1:0]     core_wdata;
    logic [2:0]            core_func3;
    logic [DATA_W-1:0]     core_rdata;
    logic                  core_stall;
    // host / debug port
    logic                  host_valid;
    logic                  host_we;
    logic [DM_ADDRESS-1:0] host_addr;
    logic [DATA_W-1:0]     host_wdata;
    logic [2:0]            host_func3;
    logic                  host_ready;
    logic                  host_rvalid;
    logic [DATA_W-1:0]     host_rdata;
    // datamemory
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_func3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata, core_func3,
        output core_rdata, core_stall,
        input  host_valid, host_we, host_addr, host_wdata, host_func3,
        output host_ready, host_rvalid, host_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata, core_func3,
        input  core_rdata, core_stall,
        output host_valid, host_we, host_addr, host_wdata, host_func3,
        input  host_ready, host_rvalid, host_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        output mem_rdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating host-starvation counter. Built only when DMEM_ARB_STARVE_EN
// is defined; hit pulses on the increment that reaches LIMIT.
`ifdef DMEM_ARB_STARVE_EN
module arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt,
    output logic       hit
);

    logic [7:0] cnt_d, cnt_q;
    logic [8:0] cnt_plus;

    assign cnt_plus = {1'b0, cnt_q} + 9'd1;
    assign hit      = inc & (cnt_plus == 9'(LIMIT));
    assign cnt      = cnt_q;

    // clear wins over increment; hold once the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (inc && (cnt_q != 8'(LIMIT))) begin
            cnt_d = cnt_plus[7:0];
        end
    end

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core MEM stage has priority over the
// host/debug port. Define DMEM_ARB_STARVE_EN to add the starvation guard
// that forces a one-cycle host grant (stalling the core) after
// STARVE_LIMIT denied cycles; otherwise priority is strict.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS   = DMEM_AW,
    parameter int DATA_W       = DMEM_DW,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    logic              core_req;
    logic              in_force;
    logic              host_sel;
    logic              core_sel;
    dmem_req_t         core_s, host_s, mem_s;
    logic              host_rvalid_d, host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_d, host_rdata_q;

    assign core_req = bus.core_rd | bus.core_wr;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_state_t state_d, state_q;
    logic            cnt_clr, cnt_inc, cnt_hit;
    logic [7:0]      unused_starve_cnt;

    assign in_force = (state_q == ARB_FORCE);
    assign cnt_inc  = ~in_force & bus.host_valid & core_req;
    assign cnt_clr  = host_sel | ~bus.host_valid | in_force;

    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk (clk),
        .rst (reset),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (unused_starve_cnt),
        .hit (cnt_hit)
    );

    // a forced cycle always lasts one cycle; enter it on the limit hit
    always_comb begin
        state_d = ARB_CORE;
        if (!in_force && cnt_hit) begin
            state_d = ARB_FORCE;
        end
    end

    // arbitration state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_CORE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT[7:0];
    assign in_force     = 1'b0;
`endif

    // Host wins when the core is idle, or in a forced cycle. If the host
    // withdrew before its forced cycle, the core keeps the port and is not
    // stalled, so its request still completes.
    assign host_sel = bus.host_valid & (in_force | ~core_req);
    assign core_sel = core_req & ~host_sel;

    // pack both requesters and pick the owner of the memory port
    always_comb begin
        core_s       = req_idle();
        core_s.rd    = bus.core_rd;
        core_s.wr    = bus.core_wr;
        core_s.addr  = bus.core_addr;
        core_s.wdata = bus.core_wdata;
        core_s.func3 = bus.core_func3;

        host_s       = req_idle();
        host_s.rd    = ~bus.host_we;
        host_s.wr    = bus.host_we;
        host_s.addr  = bus.host_addr;
        host_s.wdata = bus.host_wdata;
        host_s.func3 = bus.host_func3;

        mem_s = req_idle();
        if (host_sel) begin
            mem_s = host_s;
        end else if (core_sel) begin
            mem_s = core_s;
        end
    end

    // capture host read data on the accept cycle
    always_comb begin
        host_rvalid_d = host_sel & ~bus.host_we;
        host_rdata_d  = host_rdata_q;
        if (host_rvalid_d) begin
            host_rdata_d = bus.mem_rdata;
        end
    end

    // host response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign bus.mem_rd      = mem_s.rd;
    assign bus.mem_wr      = mem_s.wr;
    assign bus.mem_addr    = mem_s.addr[DM_ADDRESS-1:0];
    assign bus.mem_wdata   = mem_s.wdata[DATA_W-1:0];
    assign bus.mem_func3   = mem_s.func3;
    assign bus.core_rdata  = core_sel ? bus.mem_rdata : '0;
    assign bus.core_stall  = in_force & bus.host_valid & core_req;
    assign bus.host_ready  = host_sel;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural datamemory
// (combinational read, write on the rising edge).
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem_model [0:511];

    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_rd ? mem_model[bus.mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_wr) mem_model[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("[%0t] ok   %s = %h", $time, tag, obs);
        end else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_set(input logic rd, input logic wr, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
        bus.core_rd    = rd;
        bus.core_wr    = wr;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
        bus.core_func3 = f3;
    endtask

    task automatic host_set(input logic v, input logic we, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
        bus.host_valid = v;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        bus.host_func3 = f3;
    endtask

    initial begin
        reset = 1'b1;
        core_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);

        // reset values
        #2;
        chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("rst_rdata",  bus.host_rdata,       32'h0);
        chk("rst_stall",  32'(bus.core_stall),  32'd0);
        chk("rst_ready",  32'(bus.host_ready),  32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd),      32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr),      32'd0);
        step();
        step();
        reset = 1'b0;

        // preload through the host port, back-to-back writes
        host_set(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2);
        @(negedge clk); chk("pre0_ready", 32'(bus.host_ready), 32'd1);
        step();
        host_set(1'b1, 1'b1, 9'h000, 32'h11111111, 3'd2);
        @(negedge clk); chk("pre1_ready", 32'(bus.host_ready), 32'd1);
        step();
        chk("wr_no_rvalid", 32'(bus.host_rvalid), 32'd0);
        host_set(1'b1, 1'b1, 9'h004, 32'h22222222, 3'd2);
        step();
        host_set(1'b1, 1'b1, 9'h008, 32'h33333333, 3'd2);
        step();
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        chk("pre_mem8", mem_model[8], 32'h33333333);

        // idle core, host read
        host_set(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        @(negedge clk);
        chk("hr_ready",   32'(bus.host_ready), 32'd1);
        chk("hr_mem_rd",  32'(bus.mem_rd),     32'd1);
        chk("hr_addr",    32'(bus.mem_addr),   32'h010);
        chk("hr_core_rd", bus.core_rdata,      32'h0);
        step();
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        chk("hr_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("hr_rdata",  bus.host_rdata,       32'hDEADBEEF);
        step();
        chk("hr_pulse", 32'(bus.host_rvalid), 32'd0);

        // contention: core write wins, host write lands once core idles
        core_set(1'b0, 1'b1, 9'h020, 32'hAAAA0001, 3'd2);
        host_set(1'b1, 1'b1, 9'h024, 32'h55550002, 3'd1);
        @(negedge clk);
        chk("ct_ready", 32'(bus.host_ready), 32'd0);
        chk("ct_wr",    32'(bus.mem_wr),     32'd1);
        chk("ct_addr",  32'(bus.mem_addr),   32'h020);
        chk("ct_wdata", bus.mem_wdata,       32'hAAAA0001);
        chk("ct_f3",    32'(bus.mem_func3),  32'd2);
        chk("ct_stall", 32'(bus.core_stall), 32'd0);
        step();
        core_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        @(negedge clk);
        chk("ct_h_ready", 32'(bus.host_ready), 32'd1);
        chk("ct_h_addr",  32'(bus.mem_addr),   32'h024);
        chk("ct_h_f3",    32'(bus.mem_func3),  32'd1);
        step();
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        chk("ct_mem20", mem_model[9'h020], 32'hAAAA0001);
        chk("ct_mem24", mem_model[9'h024], 32'h55550002);

        // starvation: continuous core read vs pending host read
        core_set(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        host_set(1'b1, 1'b0, 9'h000, 32'h0, 3'd2);
        for (int k = 1; k <= 12; k++) begin
            logic forced;
            forced = STARVE_ON && (k == 9);
            @(negedge clk);
            chk($sformatf("sv_ready_c%0d", k), 32'(bus.host_ready), 32'(forced));
            chk($sformatf("sv_stall_c%0d", k), 32'(bus.core_stall), 32'(forced));
            chk($sformatf("sv_crd_c%0d", k), bus.core_rdata, forced ? 32'h0 : 32'hDEADBEEF);
            chk($sformatf("sv_rvalid_c%0d", k), 32'(bus.host_rvalid),
                32'(STARVE_ON && (k == 10)));
            if (STARVE_ON && k == 10) chk("sv_rdata", bus.host_rdata, 32'h11111111);
            step();
        end
        core_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        step();

        // back-to-back host reads
        host_set(1'b1, 1'b0, 9'h000, 32'h0, 3'd2);
        @(negedge clk); chk("bb_ready0", 32'(bus.host_ready), 32'd1);
        step();
        host_set(1'b1, 1'b0, 9'h004, 32'h0, 3'd2);
        chk("bb_rv0", 32'(bus.host_rvalid), 32'd1);
        chk("bb_rd0", bus.host_rdata, 32'h11111111);
        step();
        host_set(1'b1, 1'b0, 9'h008, 32'h0, 3'd2);
        chk("bb_rv1", 32'(bus.host_rvalid), 32'd1);
        chk("bb_rd1", bus.host_rdata, 32'h22222222);
        step();
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        chk("bb_rv2", 32'(bus.host_rvalid), 32'd1);
        chk("bb_rd2", bus.host_rdata, 32'h33333333);
        step();
        chk("bb_end", 32'(bus.host_rvalid), 32'd0);

        // reset in the cycle after a host read accept
        host_set(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        @(negedge clk); chk("rm_ready", 32'(bus.host_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        #1;
        chk("rm_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("rm_rdata",  bus.host_rdata,       32'h0);
        step();
        reset = 1'b0;
        step();
        chk("rm_post0", 32'(bus.host_rvalid), 32'd0);
        step();
        chk("rm_post1", 32'(bus.host_rvalid), 32'd0);

        // reset cancels a pending forced grant
        core_set(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        host_set(1'b1, 1'b0, 9'h000, 32'h0, 3'd2);
        for (int k = 0; k < 8; k++) step();
        reset = 1'b1;
        #1;
        chk("rf_stall", 32'(bus.core_stall), 32'd0);
        chk("rf_ready", 32'(bus.host_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rf_stall2", 32'(bus.core_stall), 32'd0);
        chk("rf_ready2", 32'(bus.host_ready), 32'd0);
        chk("rf_crd",    bus.core_rdata,      32'hDEADBEEF);
        step();
        core_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        host_set(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage (core) and a host/debug access port used for program/data loading and inspection. The core has priority. An optional starvation guard forces a host grant after a bounded wait, and stalls the core for that cycle. The block sits between the EX/MEM pipeline register outputs and `datamemory`; memory read data is combinational, the same cycle as the request.

## Interface

Parameters:
- `DM_ADDRESS`, 9, data-memory address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, denied host cycles before a forced grant; legal range 1..255

Ports:
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `core_rd` input 1: core MEM-stage read (`C.MemRead`)
- `core_wr` input 1: core MEM-stage write (`C.MemWrite`)
- `core_addr` input `DM_ADDRESS`: core address
- `core_wdata` input `DATA_W`: core store data
- `core_func3` input 3: core access size/sign
- `core_rdata` output `DATA_W`: read data to MEM/WB
- `core_stall` output 1: core must hold its MEM-stage request and freeze the pipeline
- `host_valid` input 1: host request pending
- `host_we` input 1: 1 = write, 0 = read
- `host_addr` input `DM_ADDRESS`: host address
- `host_wdata` input `DATA_W`: host write data
- `host_func3` input 3: host access size/sign
- `host_ready` output 1: host request accepted this cycle
- `host_rvalid` output 1: host read data valid
- `host_rdata` output `DATA_W`: registered host read data
- `mem_rd` output 1: to datamemory
- `mem_wr` output 1: to datamemory
- `mem_addr` output `DM_ADDRESS`: to datamemory
- `mem_wdata` output `DATA_W`: to datamemory
- `mem_func3` output 3: to datamemory
- `mem_rdata` input `DATA_W`: from datamemory, combinational

## Operation

- Define `core_req = core_rd | core_wr`.
- **States:** `ARB_CORE` (default) and `ARB_FORCE` (host owns the next cycle).
- **`ARB_CORE`:**
  - If `core_req`: core drives `mem_*`, `host_ready=0`, `core_stall=0`.
  - Else if `host_valid`: host drives `mem_*` (`mem_rd=~host_we`, `mem_wr=host_we`) and `host_ready=1`.
  - Else: `mem_rd=mem_wr=0`.
- **Starvation counter `starve_cnt`:**
  - Clears on any host accept or when `host_valid=0`.
  - Increments each cycle `host_valid & core_req` in `ARB_CORE`.
  - Saturates at `STARVE_LIMIT`.
  - When the increment reaches `STARVE_LIMIT`, the next state is `ARB_FORCE`.
- **`ARB_FORCE`:**
  - Host drives `mem_*` and `host_ready=1`.
  - `core_stall=core_req`.
  - The counter clears, and the next state is always `ARB_CORE`.
  - If `host_valid` dropped before the force cycle, no access is made, `core_stall=0`, and the state returns to `ARB_CORE`.
- **Host reads:**
  - On accept with `host_we=0`, `host_rdata <= mem_rdata` and `host_rvalid <= 1` at the next edge.
  - `host_rvalid` is a one-cycle pulse; there are no backpressure or ready inputs on the response.
- **Host writes:** complete in the accept cycle; no response pulse.
- **Core read data:** `core_rdata = mem_rdata` when the core owns the port, else 0.
- **Back-to-back host requests:** accepted every free cycle; `host_rvalid` may stay high on consecutive cycles.
- **`core_func3` vs `host_func3`:** routed unmodified with their owner.

## Timing

- Core access latency: 0 cycles (combinational pass-through), unchanged from the direct connection.
- Host accept to `host_rvalid`: 1 cycle.
- Worst-case host wait: `STARVE_LIMIT` + 1 cycles from `host_valid` to accept.
- Core stall: at most 1 cycle per forced grant. Consecutive forced grants are separated by at least `STARVE_LIMIT` cycles.
- **Reset values:** state `ARB_CORE`, `starve_cnt=0`, `host_rvalid=0`, `host_rdata=0`, `core_stall=0`, `host_ready=0`, `mem_rd=mem_wr=0`.
- **Reset mid-operation:** a pending `host_rvalid` is dropped and a pending `ARB_FORCE` is cancelled.

## Configuration

- **`DMEM_ARB_STARVE_EN` defined:** the starvation counter and `ARB_FORCE` are present, behaving as above.
- **Not defined:** strict core priority. No counter or `ARB_FORCE` logic is built, `core_stall` is tied to 0, and the host is served only in cycles with `core_req=0`.

## Structure

- **`Pipe_Buf_Reg_PKG` additions:**
  - `typedef enum logic {ARB_CORE, ARB_FORCE} dmem_arb_state_t`
  - `typedef struct packed {rd, wr, addr, wdata, func3} dmem_req_t`, used for core, host and mem bundles
- **Sub-module `arb_starve_cnt`:** the saturating counter with clear/increment/hit outputs. It is instantiated only under `DMEM_ARB_STARVE_EN`.

## Test plan

- **Idle core, host read:** `host_valid=1`, `host_we=0`, `host_addr=0x010`, memory holds `0xDEADBEEF` → `host_ready=1` the same cycle, `host_rvalid=1` with `host_rdata=0xDEADBEEF` the next cycle.
- **Contention:** `core_wr=1` to 0x020 and a host write to 0x024 in the same cycle → core write occurs, `host_ready=0`; when the core goes idle, the host write lands the next cycle.
- **Starvation, `STARVE_LIMIT=8` with macro:** `core_rd=1` continuously and `host_valid=1` → 8 denied cycles, then `core_stall=1` and `host_ready=1` in cycle 9; the core is served again in cycle 10.
- **Same stimulus without the macro:** `host_ready` stays 0 and `core_stall` stays 0 indefinitely.
- **Back-to-back host reads:** 0x000, 0x004, 0x008 with the core idle → `host_rvalid` high for 3 consecutive cycles with the matching data.
- **Reset mid-operation:** assert `reset` in the cycle after a host read accept → `host_rvalid=0` and state `ARB_CORE` immediately, with no response after release.
